// File: rtl/bp_pkg.sv
// Shared branch-predictor types: queued prediction entry and retire/update bundle.
// Widths here set the defaults used by the update queue and its storage.
package bp_pkg;

  localparam int BP_GHR_W = 12;
  localparam int BP_PC_W  = 32;

  typedef struct packed {
    logic [BP_PC_W-1:0]  pc;
    logic [BP_GHR_W-1:0] ghr;
    logic                global_pred;
    logic                local_pred;
    logic                final_pred;
  } bp_entry_t;

  typedef struct packed {
    logic                valid;
    logic [BP_PC_W-1:0]  pc;
    logic [BP_GHR_W-1:0] ghr;
    logic                taken;
    logic                global_correct;
    logic                local_correct;
    logic                mispredict;
  } bp_update_t;

  // Training bundle for a retiring entry; correctness flags are XNOR with the outcome.
  function automatic bp_update_t make_update(input bp_entry_t e, input logic actual);
    bp_update_t u;
    u.valid          = 1'b1;
    u.pc             = e.pc;
    u.ghr            = e.ghr;
    u.taken          = actual;
    u.global_correct = ~(e.global_pred ^ actual);
    u.local_correct  = ~(e.local_pred ^ actual);
    u.mispredict     = e.final_pred ^ actual;
    return u;
  endfunction

endpackage

// File: rtl/bq_storage.sv
// Entry array for the branch update queue: one write port, one combinational read port.
// Zero read latency; no backpressure of its own, the owner gates writes and retires.
// Only per-entry valid bits are reset; payload is written before it is ever read.
module bq_storage
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  bp_entry_t                wr_entry,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output bp_entry_t                rd_entry,
  output logic                     rd_valid,
  input  logic                     retire,
  input  logic                     flush
);

  bp_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      if (retire) valid[rd_ptr] <= 1'b0;
      if (wr_en)  valid[wr_ptr] <= 1'b1;
    end
  end

  assign rd_entry = mem[rd_ptr];
  assign rd_valid = valid[rd_ptr];

endmodule

// File: rtl/branch_update_queue.sv
// In-order queue of in-flight branch predictions; retires the head on resolve and emits training data.
// Resolve -> upd_* one cycle later (registered); enqueue visible at head one cycle later.
// pred_ready = !full from registered count only; a mispredict flushes all younger and same-cycle entries.
module branch_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GHR_W = BP_GHR_W,
  parameter int PC_W  = BP_PC_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic [GHR_W-1:0]         pred_ghr,
  input  logic                     pred_global,
  input  logic                     pred_local,
  input  logic                     pred_taken,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_pc,
  output logic [GHR_W-1:0]         upd_ghr,
  output logic                     upd_taken,
  output logic                     upd_global_correct,
  output logic                     upd_local_correct,
  output logic                     upd_mispredict,
  output logic [GHR_W-1:0]         recover_ghr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;
  logic             underflow_q;
  bp_update_t       upd_q;

  bp_entry_t        wr_entry;
  bp_entry_t        rd_entry;
  logic             head_vld;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  logic             mispredict;
  logic             wr_en;

  always_comb begin
    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    enq        = pred_valid && !full;
    deq        = resolve_valid && !empty && head_vld;
    mispredict = deq && (rd_entry.final_pred != resolve_taken);
    // A prediction arriving alongside a mispredict is already wrong-path.
    wr_en      = enq && !mispredict;

    wr_entry             = '0;
    wr_entry.pc          = pred_pc;
    wr_entry.ghr         = pred_ghr;
    wr_entry.global_pred = pred_global;
    wr_entry.local_pred  = pred_local;
    wr_entry.final_pred  = pred_taken;
  end

  bq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_ptr   (tail),
    .wr_entry (wr_entry),
    .rd_ptr   (head),
    .rd_entry (rd_entry),
    .rd_valid (head_vld),
    .retire   (deq),
    .flush    (mispredict)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (mispredict) begin
      head    <= head + 1'b1;
      tail    <= head + 1'b1;
      count_q <= '0;
    end else begin
      if (deq) head <= head + 1'b1;
      if (enq) tail <= tail + 1'b1;
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upd_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (deq) begin
        upd_q <= make_update(rd_entry, resolve_taken);
      end else begin
        upd_q.valid <= 1'b0;
      end
      if (resolve_valid && empty) underflow_q <= 1'b1;
    end
  end

  assign pred_ready         = !full;
  assign count              = count_q;
  assign underflow_err      = underflow_q;
  assign upd_valid          = upd_q.valid;
  assign upd_pc             = upd_q.pc;
  assign upd_ghr            = upd_q.ghr;
  assign upd_taken          = upd_q.taken;
  assign upd_global_correct = upd_q.global_correct;
  assign upd_local_correct  = upd_q.local_correct;
  assign upd_mispredict     = upd_q.mispredict;
  assign recover_ghr        = {upd_q.ghr[GHR_W-2:0], upd_q.taken};

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: in-order retire, full/backpressure, flush, underflow, async reset.
module tb_branch_update_queue;

  logic        clock;
  logic        reset;
  logic        pred_valid;
  logic        pred_ready;
  logic [31:0] pred_pc;
  logic [11:0] pred_ghr;
  logic        pred_global;
  logic        pred_local;
  logic        pred_taken;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [11:0] upd_ghr;
  logic        upd_taken;
  logic        upd_global_correct;
  logic        upd_local_correct;
  logic        upd_mispredict;
  logic [11:0] recover_ghr;
  logic [3:0]  count;
  logic        underflow_err;

  int checks   = 0;
  int failures = 0;

  branch_update_queue #(.DEPTH(8), .GHR_W(12), .PC_W(32)) dut (
    .clock              (clock),
    .reset              (reset),
    .pred_valid         (pred_valid),
    .pred_ready         (pred_ready),
    .pred_pc            (pred_pc),
    .pred_ghr           (pred_ghr),
    .pred_global        (pred_global),
    .pred_local         (pred_local),
    .pred_taken         (pred_taken),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .upd_valid          (upd_valid),
    .upd_pc             (upd_pc),
    .upd_ghr            (upd_ghr),
    .upd_taken          (upd_taken),
    .upd_global_correct (upd_global_correct),
    .upd_local_correct  (upd_local_correct),
    .upd_mispredict     (upd_mispredict),
    .recover_ghr        (recover_ghr),
    .count              (count),
    .underflow_err      (underflow_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pred(input logic [31:0] pc, input logic [11:0] ghr,
                      input logic g, input logic l, input logic t);
    pred_valid  = 1'b1;
    pred_pc     = pc;
    pred_ghr    = ghr;
    pred_global = g;
    pred_local  = l;
    pred_taken  = t;
  endtask

  task automatic resolve(input logic t);
    resolve_valid = 1'b1;
    resolve_taken = t;
  endtask

  task automatic idle();
    pred_valid    = 1'b0;
    resolve_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pred_valid = 1'b0; pred_pc = '0; pred_ghr = '0;
    pred_global = 1'b0; pred_local = 1'b0; pred_taken = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready",     32'(pred_ready), 32'h1);
    chk("rst_upd_valid", 32'(upd_valid), 32'h0);
    chk("rst_count",     32'(count), 32'h0);
    chk("rst_underflow", 32'(underflow_err), 32'h0);
    chk("rst_upd_pc",    upd_pc, 32'h0);
    chk("rst_recover",   32'(recover_ghr), 32'h0);
    chk("rst_mispred",   32'(upd_mispredict), 32'h0);
    reset = 1'b0;

    // Three correct predictions retire in order.
    pred(32'h100, 12'h001, 1'b1, 1'b0, 1'b1); step();
    pred(32'h104, 12'h010, 1'b0, 1'b1, 1'b0); step();
    pred(32'h108, 12'h800, 1'b1, 1'b1, 1'b1); step();
    idle();
    chk("t1_count3", 32'(count), 32'h3);
    resolve(1'b1); step();
    chk("t1_r0_valid", 32'(upd_valid), 32'h1);
    chk("t1_r0_pc",    upd_pc, 32'h100);
    chk("t1_r0_misp",  32'(upd_mispredict), 32'h0);
    chk("t1_r0_gcor",  32'(upd_global_correct), 32'h1);
    chk("t1_r0_lcor",  32'(upd_local_correct), 32'h0);
    chk("t1_r0_rec",   32'(recover_ghr), 32'h003);
    resolve(1'b0); step();
    chk("t1_r1_valid", 32'(upd_valid), 32'h1);
    chk("t1_r1_pc",    upd_pc, 32'h104);
    chk("t1_r1_taken", 32'(upd_taken), 32'h0);
    chk("t1_r1_misp",  32'(upd_mispredict), 32'h0);
    chk("t1_r1_lcor",  32'(upd_local_correct), 32'h0);
    chk("t1_r1_rec",   32'(recover_ghr), 32'h020);
    resolve(1'b1); step();
    chk("t1_r2_valid", 32'(upd_valid), 32'h1);
    chk("t1_r2_pc",    upd_pc, 32'h108);
    chk("t1_r2_ghr",   32'(upd_ghr), 32'h800);
    chk("t1_r2_rec",   32'(recover_ghr), 32'h001);
    chk("t1_count0",   32'(count), 32'h0);
    idle(); step();
    chk("t1_pulse_end", 32'(upd_valid), 32'h0);

    // Fill to full; a ninth prediction is dropped.
    for (int i = 0; i < 8; i++) begin
      pred(32'h300 + 32'(4 * i), 12'(i), 1'b1, 1'b1, 1'b1);
      step();
    end
    chk("t2_full_count", 32'(count), 32'h8);
    chk("t2_full_ready", 32'(pred_ready), 32'h0);
    pred(32'h400, 12'h0FF, 1'b1, 1'b1, 1'b1); step();
    chk("t2_drop_count", 32'(count), 32'h8);
    pred_valid = 1'b0;
    resolve(1'b1);
    chk("t2_ready_while_resolving", 32'(pred_ready), 32'h0);
    step();
    chk("t2_after_res_pc",    upd_pc, 32'h300);
    chk("t2_after_res_count", 32'(count), 32'h7);
    chk("t2_after_res_ready", 32'(pred_ready), 32'h1);
    for (int i = 0; i < 7; i++) step();
    idle();
    chk("t2_last_pc",    upd_pc, 32'h31C);
    chk("t2_last_valid", 32'(upd_valid), 32'h1);
    chk("t2_drained",    32'(count), 32'h0);
    step();
    chk("t2_no_ninth",   32'(upd_valid), 32'h0);

    // Mispredict repairs history and flushes younger entries.
    pred(32'h200, 12'hABC, 1'b0, 1'b1, 1'b1); step();
    pred(32'h204, 12'h111, 1'b1, 1'b1, 1'b1); step();
    pred(32'h208, 12'h222, 1'b1, 1'b1, 1'b1); step();
    idle();
    chk("t3_count3", 32'(count), 32'h3);
    resolve(1'b0); step();
    resolve_valid = 1'b0;
    chk("t3_valid",   32'(upd_valid), 32'h1);
    chk("t3_pc",      upd_pc, 32'h200);
    chk("t3_misp",    32'(upd_mispredict), 32'h1);
    chk("t3_taken",   32'(upd_taken), 32'h0);
    chk("t3_gcor",    32'(upd_global_correct), 32'h1);
    chk("t3_lcor",    32'(upd_local_correct), 32'h0);
    chk("t3_recover", 32'(recover_ghr), 32'h578);
    chk("t3_flushed", 32'(count), 32'h0);
    step();
    chk("t3_pulse_end", 32'(upd_valid), 32'h0);
    chk("t3_no_uf",     32'(underflow_err), 32'h0);
    pred(32'h500, 12'h005, 1'b1, 1'b1, 1'b1); step();
    idle(); resolve(1'b1); step();
    resolve_valid = 1'b0;
    chk("t3_post_flush_pc", upd_pc, 32'h500);

    // Enqueue plus correct resolve with four entries held.
    for (int i = 0; i < 4; i++) begin
      pred(32'h600 + 32'(4 * i), 12'h060, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("t4_count4", 32'(count), 32'h4);
    pred(32'h610, 12'h061, 1'b0, 1'b0, 1'b0);
    resolve(1'b0); step();
    idle();
    chk("t4_count_hold", 32'(count), 32'h4);
    chk("t4_valid",      32'(upd_valid), 32'h1);
    chk("t4_pc",         upd_pc, 32'h600);
    chk("t4_misp",       32'(upd_mispredict), 32'h0);

    // Mispredict with a same-cycle prediction: the new entry is wrong-path.
    pred(32'h700, 12'h070, 1'b1, 1'b1, 1'b1);
    resolve(1'b1); step();
    idle();
    chk("t5_pc",    upd_pc, 32'h604);
    chk("t5_misp",  32'(upd_mispredict), 32'h1);
    chk("t5_count", 32'(count), 32'h0);
    step();
    chk("t5_count_next", 32'(count), 32'h0);
    pred(32'h710, 12'h071, 1'b1, 1'b1, 1'b1); step();
    idle(); resolve(1'b1); step();
    resolve_valid = 1'b0;
    chk("t5_next_pc", upd_pc, 32'h710);

    // Resolve on an empty queue.
    step();
    resolve(1'b1); step();
    resolve_valid = 1'b0;
    chk("t6_no_valid",  32'(upd_valid), 32'h0);
    chk("t6_underflow", 32'(underflow_err), 32'h1);
    chk("t6_count",     32'(count), 32'h0);
    step(); step();
    chk("t6_uf_sticky", 32'(underflow_err), 32'h1);

    // Asynchronous reset mid-fill.
    pred(32'h800, 12'h080, 1'b1, 1'b1, 1'b1); step();
    pred(32'h804, 12'h081, 1'b1, 1'b1, 1'b1); step();
    idle();
    chk("t7_count2", 32'(count), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("t7_async_count", 32'(count), 32'h0);
    chk("t7_async_uf",    32'(underflow_err), 32'h0);
    chk("t7_async_ready", 32'(pred_ready), 32'h1);
    #2;
    reset = 1'b0;
    step();
    chk("t7_post_count", 32'(count), 32'h0);
    chk("t7_post_valid", 32'(upd_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
